// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU control encodings, multiplier sequencer state type and default width.
package alu_pkg;

    localparam int WIDTH_DEFAULT = 64;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } seq_state_t;

endpackage

// File: rtl/alu_mult_sequencer_if.sv
// rtl/alu_mult_sequencer_if.sv - Start/Ready/Done handshake and operand/result bus of the multiplier.
interface alu_mult_sequencer_if #(
    parameter int WIDTH = alu_pkg::WIDTH_DEFAULT
) ();
    logic             Start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Ready;
    logic             Done;
    logic [WIDTH-1:0] Product;
    logic             ProductZero;

    modport master (
        output Start, A, B,
        input  Ready, Done, Product, ProductZero
    );

    modport slave (
        input  Start, A, B,
        output Ready, Done, Product, ProductZero
    );
endinterface

// File: rtl/alu.sv
// rtl/alu.sv - Combinational ALU (AND/OR/ADD/SUB/PassB) with zero flag.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] BusA,
    input  logic [WIDTH-1:0] BusB,
    input  logic [3:0]       ALUCtrl,
    output logic [WIDTH-1:0] BusW,
    output logic             Zero
);
    always_comb begin
        BusW = '0;
        case (ALUCtrl)
            ALU_AND:   BusW = BusA & BusB;
            ALU_OR:    BusW = BusA | BusB;
            ALU_ADD:   BusW = BusA + BusB;
            ALU_SUB:   BusW = BusA - BusB;
            ALU_PASSB: BusW = BusB;
            default:   BusW = '0;
        endcase
    end

    assign Zero = (BusW == '0);
endmodule

// File: rtl/alu_mult_sequencer.sv
// rtl/alu_mult_sequencer.sv - Shift-add multiplier sequencing one ALU in ADD mode; low WIDTH bits of A*B.
// Optional ALU_MULT_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all zero.
module alu_mult_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = 7
) (
    input  logic                 CLK,
    input  logic                 Reset,
    alu_mult_sequencer_if.slave  bus
);
    seq_state_t       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] product_q, product_d;
    logic             product_zero_q, product_zero_d;
    logic [WIDTH-1:0] alu_busw;
    logic [WIDTH-1:0] acc_step;

    alu #(.WIDTH(WIDTH)) u_alu (
        .BusA    (acc_q),
        .BusB    (mcand_q),
        .ALUCtrl (ALU_ADD),
        .BusW    (alu_busw),
        .Zero    ()
    );

    // Partial product is accumulated only when the current multiplier LSB is set.
    assign acc_step = mplier_q[0] ? alu_busw : acc_q;

    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        mcand_d        = mcand_q;
        mplier_d       = mplier_q;
        cnt_d          = cnt_q;
        product_d      = product_q;
        product_zero_d = product_zero_q;
        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    mcand_d  = bus.A;
                    mplier_d = bus.B;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
`ifdef ALU_MULT_EARLY_TERM_EN
                if (mplier_q == '0) begin
                    state_d        = DONE;
                    product_d      = acc_q;
                    product_zero_d = (acc_q == '0);
                end else
`endif
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d        = DONE;
                    product_d      = acc_step;
                    product_zero_d = (acc_step == '0);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q        <= IDLE;
            acc_q          <= '0;
            mcand_q        <= '0;
            mplier_q       <= '0;
            cnt_q          <= '0;
            product_q      <= '0;
            product_zero_q <= 1'b1;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            mcand_q        <= mcand_d;
            mplier_q       <= mplier_d;
            cnt_q          <= cnt_d;
            product_q      <= product_d;
            product_zero_q <= product_zero_d;
        end
    end

    assign bus.Ready       = (state_q == IDLE);
    assign bus.Done        = (state_q == DONE);
    assign bus.Product     = product_q;
    assign bus.ProductZero = product_zero_q;
endmodule
